// File: rtl/ball_tick_sync_if.sv
// ball_tick_sync_if: refresh-clock sampler bundle.
//   clk_in, timeout        -> into the sampler (master drives)
//   tick, tick_fall,
//   period, period_valid,
//   stalled                <- out of the sampler (slave drives)
interface ball_tick_sync_if #(parameter int CNT_W = 22);
  logic             clk_in;
  logic [CNT_W-1:0] timeout;
  logic             tick;
  logic             tick_fall;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;
  modport master (output clk_in, timeout, input tick, tick_fall, period, period_valid, stalled);
  modport slave  (input clk_in, timeout, output tick, tick_fall, period, period_valid, stalled);
endinterface

// File: rtl/ball_tick_sync.sv
// ball_tick_sync: resample divided refresh clock into clk_50MHz, tick per edge, period/stall monitor.
//   clk_50MHz, reset (async, active-high) plain ports; everything else on bus (slave modport).
//   Optional macro BALL_TICK_FALL_EN adds the falling-edge tick; otherwise tick_fall is tied 0.
module ball_tick_sync #(parameter int CNT_W = 22) (
  input  logic             clk_50MHz,
  input  logic             reset,
  ball_tick_sync_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;
  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, cnt_inc;
  logic             tick_q, tick_d, valid_q, valid_d, stalled_q, stalled_d;
  logic             rise, hit;
  always_comb begin
    sync_d    = {sync_q[1:0], bus.clk_in};
    rise      = sync_q[1] & ~sync_q[2];
    tick_d    = rise;
    cnt_inc   = &cnt_q ? cnt_q : cnt_q + 1'b1;
    // equality-only compare: a timeout lowered below cnt never fires until cnt restarts
    hit       = (bus.timeout != '0) && (cnt_q == bus.timeout);
    state_d   = state_q;
    cnt_d     = cnt_inc;
    period_d  = period_q;
    valid_d   = valid_q;
    stalled_d = stalled_q;
    case (state_q)
      IDLE: begin
        state_d = rise ? MEASURE : IDLE;
        cnt_d   = rise ? CNT_W'(1) : cnt_inc;
      end
      MEASURE: begin
        cnt_d     = rise ? CNT_W'(1) : cnt_inc;
        period_d  = rise ? cnt_q : period_q;
        valid_d   = rise | (valid_q & ~hit);
        stalled_d = ~rise & hit;
        state_d   = (~rise & hit) ? STALL : MEASURE;
      end
      STALL: begin
        // first edge after a stall only restarts the measurement
        cnt_d     = rise ? CNT_W'(1) : cnt_q;
        stalled_d = ~rise;
        state_d   = rise ? MEASURE : STALL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      tick_q    <= tick_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
`ifdef BALL_TICK_FALL_EN
  logic fall_q, fall_d;
  always_comb fall_d = ~sync_q[1] & sync_q[2];
  always_ff @(posedge clk_50MHz or posedge reset)
    if (reset) fall_q <= 1'b0;
    else fall_q <= fall_d;
  assign bus.tick_fall = fall_q;
`else
  assign bus.tick_fall = 1'b0;
`endif
  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.stalled      = stalled_q;
endmodule

// File: tb/tb_ball_tick_sync.sv
// tb_ball_tick_sync: randomized + directed bench against an edge-history reference model.
module tb_ball_tick_sync;
  localparam int W = 10;
  localparam int MAX = (1 << W) - 1;
`ifdef BALL_TICK_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif
  logic clk_50MHz = 1'b0;
  logic reset;
  logic chk_en;
  int checks = 0;
  int errors = 0;
  ball_tick_sync_if #(.CNT_W(W)) bus();
  ball_tick_sync #(.CNT_W(W)) dut (.clk_50MHz(clk_50MHz), .reset(reset), .bus(bus));
  always #5 clk_50MHz = ~clk_50MHz;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  bit hist[$];
  bit seen, r, f;
  int n, el, last_rise;
  logic m_tick, m_fall, m_valid, m_stalled;
  logic [W-1:0] m_period;
  always @(posedge clk_50MHz or posedge reset)
    if (reset) begin
      hist.delete();
      repeat (3) hist.push_back(1'b0);
      seen = 0; last_rise = 0;
      m_tick = 0; m_fall = 0; m_valid = 0; m_stalled = 0; m_period = '0;
    end else begin
      hist.push_back(bus.clk_in);
      n = hist.size() - 1;
      r = hist[n-2] && !hist[n-3];
      f = !hist[n-2] && hist[n-3];
      el = (n - last_rise > MAX) ? MAX : n - last_rise;
      if (r) begin
        if (seen && !m_stalled) begin
          m_period = W'(el);
          m_valid = 1;
        end
        seen = 1; m_stalled = 0; last_rise = n;
      end else if (seen && !m_stalled && bus.timeout != 0 && el == int'(bus.timeout)) begin
        m_stalled = 1;
        m_valid = 0;
      end
      m_tick = r;
      m_fall = FALL_EN & f;
    end
  always @(negedge clk_50MHz)
    if (chk_en && !reset) begin
      check("tick", 32'(bus.tick), 32'(m_tick));
      check("tick_fall", 32'(bus.tick_fall), 32'(m_fall));
      check("period", 32'(bus.period), 32'(m_period));
      check("period_valid", 32'(bus.period_valid), 32'(m_valid));
      check("stalled", 32'(bus.stalled), 32'(m_stalled));
    end
  task automatic run(input int hi, input int lo, input int cycles);
    repeat (cycles) begin
      bus.clk_in = 1'b1;
      repeat (hi) @(negedge clk_50MHz);
      bus.clk_in = 1'b0;
      repeat (lo) @(negedge clk_50MHz);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_tick"}, 32'(bus.tick), 0);
    check({tag, "_fall"}, 32'(bus.tick_fall), 0);
    check({tag, "_period"}, 32'(bus.period), 0);
    check({tag, "_valid"}, 32'(bus.period_valid), 0);
    check({tag, "_stalled"}, 32'(bus.stalled), 0);
  endtask
  initial begin
    int k;
    bus.clk_in = 1'b0; bus.timeout = '0; reset = 1'b0; chk_en = 1'b0;
    #3 reset = 1'b1;
    #20 check_zero("reset");
    @(negedge clk_50MHz); #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_50MHz);
    run(4, 4, 10);
    check("p8_period", 32'(bus.period), 8);
    check("p8_valid", 32'(bus.period_valid), 1);
    bus.timeout = W'(20);
    for (k = 0; k < 60 && !bus.stalled; k++) @(negedge clk_50MHz);
    check("stall_seen", 32'(bus.stalled), 1);
    check("stall_valid", 32'(bus.period_valid), 0);
    check("stall_period", 32'(bus.period), 8);
    run(6, 6, 1);
    check("restart_stalled", 32'(bus.stalled), 0);
    check("restart_period", 32'(bus.period), 8);
    run(6, 6, 2);
    check("p12_period", 32'(bus.period), 12);
    bus.timeout = '0;
    run(4, 4, 3);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk_50MHz); #2 reset = 1'b0;
    @(negedge clk_50MHz);
    run(4, 4, 1);
    check("post_rst_valid", 32'(bus.period_valid), 0);
    check("post_rst_period", 32'(bus.period), 0);
    run(4, 4, 2);
    check("post_rst_p8", 32'(bus.period), 8);
    bus.timeout = W'(8);
    run(4, 4, 6);
    check("to8_stalled", 32'(bus.stalled), 0);
    check("to8_period", 32'(bus.period), 8);
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) bus.timeout = W'($urandom_range(0, 30));
      run($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) begin
        bus.clk_in = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk_50MHz);
      end
    end
    bus.timeout = '0;
    run(4, 4, 2);
    repeat (MAX + 100) @(negedge clk_50MHz);
    run(4, 4, 1);
    check("sat_period", 32'(bus.period), MAX);
    check("sat_valid", 32'(bus.period_valid), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
